// File: rtl/or_share_sched.sv
// Round-robin scheduler that shares one WIDTH-bit OR datapath among four
// requesters. A request is granted, its operands are captured, the pair goes
// through the per-bit OR array, and the registered result is held under
// valid/ready until the consumer takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for any req; grants the round-robin winner on an edge
// EXEC  | operands latched; OR result registered on the next edge
// DONE  | result valid; held until out_ready is seen at an edge

module or_node (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module or_share_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_flat,
  input  logic [4*WIDTH-1:0]   b_flat,
  input  logic                 out_ready,
  output logic [3:0]           gnt,
  output logic                 out_valid,
  output logic [1:0]           out_id,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [1:0]         out_id_q, out_id_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   or_res;
  logic [1:0]         win;
  logic               found;
  logic [1:0]         idx;

  // Shared datapath: one OR cell per bit, fed from the captured operands.
  for (genvar i = 0; i < WIDTH; i++) begin : g_or
    or_node u_or_node (
      .a (opa_q[i]),
      .b (opb_q[i]),
      .y (or_res[i])
    );
  end

  // Round-robin pick: first set request scanning from ptr upward, wrapping.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = 4'b0000;
    opa_d       = opa_q;
    opb_d       = opb_q;
    out_id_d    = out_id_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d    = 4'b0001 << win;
          opa_d    = a_flat[win*WIDTH +: WIDTH];
          opb_d    = b_flat[win*WIDTH +: WIDTH];
          out_id_d = win;
          ptr_d    = win + 2'd1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        out_d       = or_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      opa_q       <= '0;
      opb_q       <= '0;
      out_id_q    <= 2'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      out_id_q    <= out_id_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out       = out_q;
  assign busy      = (state_q != IDLE);

endmodule
